// File: rtl/ac97_wb_arbiter.sv
// Two-master Wishbone arbiter sharing one RAM slave between the AC97 DMA engine (m0) and the host loader (m1).
// Optional stall watchdog: define AC97_WB_ARB_TIMEOUT_EN to enable the TIMEOUT_CYCLES limit and the err pulse.
module ac97_wb_arbiter #(
  parameter int ADR_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  // master 0: AC97 DMA
  input  logic [ADR_WIDTH-1:0] m0_adr_i,
  input  logic [31:0]          m0_dat_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic [2:0]           m0_cti_i,
  output logic [31:0]          m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  // master 1: host / loader
  input  logic [ADR_WIDTH-1:0] m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic [2:0]           m1_cti_i,
  output logic [31:0]          m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  // shared slave
  output logic [ADR_WIDTH-1:0] s_adr_o,
  output logic [31:0]          s_dat_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic [2:0]           s_cti_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i,
  output logic [1:0]           gnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_m1;
  logic   w_timeout;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("ac97_wb_arbiter: TIMEOUT_CYCLES must lie in 1..255");
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_last_m1 <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == ST_GNT0) begin
        r_last_m1 <= 1'b0;
      end else if (w_next == ST_GNT1) begin
        r_last_m1 <= 1'b1;
      end
    end
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next = r_last_m1 ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          w_next = ST_GNT0;
        end else if (m1_cyc_i) begin
          w_next = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (w_timeout) begin
          w_next = ST_IDLE;
        end else if (!m0_cyc_i) begin
          w_next = m1_cyc_i ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (w_timeout) begin
          w_next = ST_IDLE;
        end else if (!m1_cyc_i) begin
          w_next = m0_cyc_i ? ST_GNT0 : ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

`ifdef AC97_WB_ARB_TIMEOUT_EN
  localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] r_wdog;
  logic       w_stall;

  // A stalled cycle is one where the granted master strobes and the slave does not answer.
  assign w_stall = ((r_state == ST_GNT0) && m0_stb_i && !s_ack_i) ||
                   ((r_state == ST_GNT1) && m1_stb_i && !s_ack_i);

  assign w_timeout = (r_state != ST_IDLE) && (r_wdog == LP_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= 8'd0;
    end else if ((w_next != r_state) || s_ack_i) begin
      r_wdog <= 8'd0;
    end else if (w_stall) begin
      r_wdog <= r_wdog + 8'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    s_adr_o  = m0_adr_i;
    s_dat_o  = m0_dat_i;
    s_we_o   = m0_we_i;
    s_cti_o  = m0_cti_i;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (r_state)
      ST_GNT0: begin
        s_cyc_o  = m0_cyc_i && !w_timeout;
        s_stb_o  = m0_stb_i && !w_timeout;
        m0_ack_o = s_ack_i && !w_timeout;
        m0_err_o = w_timeout;
      end
      ST_GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_cti_o  = m1_cti_i;
        s_cyc_o  = m1_cyc_i && !w_timeout;
        s_stb_o  = m1_stb_i && !w_timeout;
        m1_ack_o = s_ack_i && !w_timeout;
        m1_err_o = w_timeout;
      end
      default: ;
    endcase
  end

  // Read data fans out to both masters; only the ack qualifies it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt      = {r_state == ST_GNT1, r_state == ST_GNT0};

endmodule
